// File: rtl/rs485_pkg.sv
// rs485_pkg: shared state encoding and timing constants for the RS485 reply scheduler.
// Rev 1.0
`default_nettype none

package rs485_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_RXEND  = 4'd1,
      S_PAUSE  = 4'd2,
      S_SETUP  = 4'd3,
      S_LOAD   = 4'd4,
      S_ISSUE  = 4'd5,
      S_WAITLO = 4'd6,
      S_WAITHI = 4'd7,
      S_GUARD  = 4'd8
   } state_t;

   localparam logic [7:0] REQ_CODE_DEF = 8'd66;

   // UART TX must drop txReady within this many clocks of txStart, else the start is re-sent
   localparam int RETRY_CLKS = 2;

endpackage

`default_nettype wire

// File: rtl/rs485_cksum8.sv
// rs485_cksum8: mod-256 running sum of frame payload bytes.
// Rev 1.0
`default_nettype none

module rs485_cksum8 (
   input  logic       clk,
   input  logic       nRST,
   input  logic       clear,
   input  logic       add_en,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   always_ff @(posedge clk) begin
      if (!nRST) begin
         sum <= 8'd0;
      end else if (clear) begin
         sum <= 8'd0;
      end else if (add_en) begin
         sum <= sum + din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rs485_tx_sched.sv
// rs485_tx_sched: half-duplex RS485 reply scheduler (request detect, turnaround pause, framed reply, guard).
// Rev 1.0. Optional trailing checksum byte: define RS485_CKSUM_EN.
`default_nettype none

module rs485_tx_sched
   import rs485_pkg::*;
#(
   parameter logic [7:0] REQ_CODE   = REQ_CODE_DEF,
   parameter int         PAUSE_CLKS = 200,
   parameter int         SETUP_CLKS = 4,
   parameter int         GUARD_CLKS = 16,
   parameter int         FRAME_LEN  = 8
) (
   input  logic       clk,
   input  logic       nRST,
   input  logic       rValid,
   input  logic [7:0] rxData,
   input  logic       txReady,
   output logic       txStart,
   output logic [7:0] txData,
   output logic [7:0] rdAddr,
   input  logic [7:0] rdData,
   output logic       dirTX,
   output logic       busy,
   output logic       frameDone,
   output logic       errAbort
);

   localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_CLKS - 1);
   localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CLKS - 1);
   localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CLKS - 1);
   localparam logic [7:0]  FRAME_LAST = 8'(FRAME_LEN - 1);
   localparam logic [1:0]  RETRY_LAST = 2'(RETRY_CLKS - 1);

   state_t      state;
   logic [15:0] pause_cnt;
   logic [7:0]  setup_cnt;
   logic [7:0]  guard_cnt;
   logic [7:0]  byte_idx;
   logic [1:0]  retry_cnt;

`ifdef RS485_CKSUM_EN
   logic [7:0] cksum;
   logic       ck_phase;

   rs485_cksum8 u_cksum (
      .clk    (clk),
      .nRST   (nRST),
      .clear  (state == S_SETUP),
      .add_en (state == S_LOAD),
      .din    (rdData),
      .sum    (cksum)
   );
`endif

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state     <= S_IDLE;
         pause_cnt <= 16'd0;
         setup_cnt <= 8'd0;
         guard_cnt <= 8'd0;
         byte_idx  <= 8'd0;
         retry_cnt <= 2'd0;
         txStart   <= 1'b0;
         txData    <= 8'd0;
         rdAddr    <= 8'd0;
         dirTX     <= 1'b0;
         busy      <= 1'b0;
         frameDone <= 1'b0;
         errAbort  <= 1'b0;
`ifdef RS485_CKSUM_EN
         ck_phase  <= 1'b0;
`endif
      end else begin
         txStart   <= 1'b0;
         frameDone <= 1'b0;
         errAbort  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rValid && (rxData == REQ_CODE)) begin
                  state <= S_RXEND;
                  busy  <= 1'b1;
               end
            end
            S_RXEND: begin
               if (!rValid) begin
                  state     <= S_PAUSE;
                  pause_cnt <= 16'd0;
               end
            end
            S_PAUSE: begin
               // Another master talking inside our turnaround: back off and wait for it to finish
               if (rValid) begin
                  errAbort <= 1'b1;
                  state    <= S_RXEND;
               end else if (pause_cnt == PAUSE_LAST) begin
                  state     <= S_SETUP;
                  dirTX     <= 1'b1;
                  setup_cnt <= 8'd0;
                  byte_idx  <= 8'd0;
                  rdAddr    <= 8'd0;
`ifdef RS485_CKSUM_EN
                  ck_phase  <= 1'b0;
`endif
               end else begin
                  pause_cnt <= pause_cnt + 16'd1;
               end
            end
            S_SETUP: begin
               if (setup_cnt == SETUP_LAST) begin
                  state <= S_LOAD;
               end else begin
                  setup_cnt <= setup_cnt + 8'd1;
               end
            end
            S_LOAD: begin
               txData <= rdData;
               state  <= S_ISSUE;
            end
            S_ISSUE: begin
               if (txReady) begin
                  txStart   <= 1'b1;
                  retry_cnt <= 2'd0;
                  state     <= S_WAITLO;
               end
            end
            S_WAITLO: begin
               if (!txReady) begin
                  state <= S_WAITHI;
               end else if (retry_cnt == RETRY_LAST) begin
                  txStart   <= 1'b1;
                  retry_cnt <= 2'd0;
               end else begin
                  retry_cnt <= retry_cnt + 2'd1;
               end
            end
            S_WAITHI: begin
               if (txReady) begin
`ifdef RS485_CKSUM_EN
                  if (ck_phase) begin
                     state     <= S_GUARD;
                     guard_cnt <= 8'd0;
                  end else if (byte_idx == FRAME_LAST) begin
                     ck_phase <= 1'b1;
                     txData   <= cksum;
                     state    <= S_ISSUE;
                  end else begin
                     byte_idx <= byte_idx + 8'd1;
                     rdAddr   <= rdAddr + 8'd1;
                     state    <= S_LOAD;
                  end
`else
                  if (byte_idx == FRAME_LAST) begin
                     state     <= S_GUARD;
                     guard_cnt <= 8'd0;
                  end else begin
                     byte_idx <= byte_idx + 8'd1;
                     rdAddr   <= rdAddr + 8'd1;
                     state    <= S_LOAD;
                  end
`endif
               end
            end
            S_GUARD: begin
               if (guard_cnt == GUARD_LAST) begin
                  dirTX     <= 1'b0;
                  busy      <= 1'b0;
                  frameDone <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  guard_cnt <= guard_cnt + 8'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               dirTX <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
